// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with seed load, counted bursts, lock-up recovery and period measurement.
// Optional scrambler mode folds a serial input into the feedback.
module lfsr_gen #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'hC9,
  parameter logic [WIDTH-1:0]  SEED  = 8'h01,
  parameter bit                XNOR  = 1'b0,
  parameter int unsigned       CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rs,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed_in,
  input  logic             i_scr,
  input  logic             i_din,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_nsteps,
  output logic [WIDTH-1:0] o_state,
  output logic             o_sout,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap,
  output logic             o_lockup,
  output logic [WIDTH-1:0] o_period
);

  localparam logic [WIDTH-1:0] LOCK_VAL = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic {StIdle, StRun} fsm_e;

  fsm_e             r_fsm, w_fsm_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_state, r_ref, r_cnt, r_period;
  logic             r_done, r_wrap, r_lockup;
  logic             w_done_nxt, w_do_step, w_fb;
  logic [WIDTH-1:0] w_step_nxt;

  always_comb begin
    w_fb       = (^(r_state & TAPS)) ^ XNOR ^ (i_scr & i_din);
    w_step_nxt = {r_state[WIDTH-2:0], w_fb};
  end

  // Burst control; an accepted start suppresses the en step in the same cycle.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_rem_nxt  = r_rem;
    w_done_nxt = 1'b0;
    w_do_step  = 1'b0;
    unique case (r_fsm)
      StIdle: begin
        if (i_start) begin
          if (i_nsteps != '0) begin
            w_fsm_nxt = StRun;
            w_rem_nxt = i_nsteps;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          w_do_step = i_en;
        end
      end
      StRun: begin
        w_do_step = 1'b1;
        w_rem_nxt = r_rem - 1'b1;
        if (r_rem == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          w_fsm_nxt  = StIdle;
          w_done_nxt = 1'b1;
        end
      end
      default: w_fsm_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rs) begin
      r_fsm    <= StIdle;
      r_rem    <= '0;
      r_state  <= SEED;
      r_ref    <= SEED;
      r_cnt    <= '0;
      r_period <= '0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
      if (i_load) begin
        r_fsm   <= StIdle;
        r_rem   <= '0;
        r_done  <= 1'b0;
        r_state <= i_seed_in;
        r_ref   <= i_seed_in;
        r_cnt   <= '0;
      end else begin
        r_fsm  <= w_fsm_nxt;
        r_rem  <= w_rem_nxt;
        r_done <= w_done_nxt;
        if (w_do_step) begin
          if (r_state == LOCK_VAL) begin
            r_state  <= SEED;
            r_lockup <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_state <= w_step_nxt;
            if (w_step_nxt == r_ref) begin
              r_period <= r_cnt + 1'b1;
              r_wrap   <= 1'b1;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_state  = r_state;
  assign o_sout   = r_state[WIDTH-1];
  assign o_busy   = (r_fsm == StRun);
  assign o_done   = r_done;
  assign o_wrap   = r_wrap;
  assign o_lockup = r_lockup;
  assign o_period = r_period;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: table-driven vectors on an 8-bit XOR instance, plus period,
// XNOR lock-up and scrambler sequences; expected results go through a scoreboard queue.
module tb_lfsr_gen;

  typedef struct {
    logic        rs, en, load, start;
    logic [7:0]  seed;
    logic [15:0] nsteps;
    logic [7:0]  st;
    logic        busy, done, lockup;
  } vec_t;

  typedef struct {
    logic [7:0] st;
    logic       sout, busy, done, wrap, lockup;
    logic [7:0] period;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  // Instance A: WIDTH=8, TAPS=C9, SEED=01, XOR
  logic        a_rs, a_en, a_load, a_scr, a_din, a_start;
  logic [7:0]  a_seed;
  logic [15:0] a_nsteps;
  logic [7:0]  a_state, a_period;
  logic        a_sout, a_busy, a_done, a_wrap, a_lockup;

  // Instance B: WIDTH=4, TAPS=9, SEED=1
  logic        rs_bc, b_en;
  logic [3:0]  b_seed;
  logic [3:0]  b_state, b_period;
  logic        b_sout, b_busy, b_done, b_wrap, b_lockup;

  // Instance C: WIDTH=8, TAPS=C9, SEED=00, XNOR
  logic        c_en, c_load;
  logic [7:0]  c_seed;
  logic [7:0]  c_state, c_period;
  logic        c_sout, c_busy, c_done, c_wrap, c_lockup;

  logic        z1 = 1'b0;
  logic [15:0] z16 = 16'd0;

  lfsr_gen #(.WIDTH(8), .TAPS(8'hC9), .SEED(8'h01), .XNOR(1'b0), .CNT_W(16)) u_a (
    .i_clk(clk), .i_rs(a_rs), .i_en(a_en), .i_load(a_load), .i_seed_in(a_seed),
    .i_scr(a_scr), .i_din(a_din), .i_start(a_start), .i_nsteps(a_nsteps),
    .o_state(a_state), .o_sout(a_sout), .o_busy(a_busy), .o_done(a_done),
    .o_wrap(a_wrap), .o_lockup(a_lockup), .o_period(a_period)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .XNOR(1'b0), .CNT_W(16)) u_b (
    .i_clk(clk), .i_rs(rs_bc), .i_en(b_en), .i_load(z1), .i_seed_in(b_seed),
    .i_scr(z1), .i_din(z1), .i_start(z1), .i_nsteps(z16),
    .o_state(b_state), .o_sout(b_sout), .o_busy(b_busy), .o_done(b_done),
    .o_wrap(b_wrap), .o_lockup(b_lockup), .o_period(b_period)
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'hC9), .SEED(8'h00), .XNOR(1'b1), .CNT_W(16)) u_c (
    .i_clk(clk), .i_rs(rs_bc), .i_en(c_en), .i_load(c_load), .i_seed_in(c_seed),
    .i_scr(z1), .i_din(z1), .i_start(z1), .i_nsteps(z16),
    .o_state(c_state), .o_sout(c_sout), .o_busy(c_busy), .o_done(c_done),
    .o_wrap(c_wrap), .o_lockup(c_lockup), .o_period(c_period)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] st, input logic sout, input logic busy,
                      input logic done, input logic wrap, input logic lockup,
                      input logic [7:0] period);
    exp_t e;
    e.st = st; e.sout = sout; e.busy = busy; e.done = done;
    e.wrap = wrap; e.lockup = lockup; e.period = period;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag, input logic [7:0] st, input logic sout,
                         input logic busy, input logic done, input logic wrap,
                         input logic lockup, input logic [7:0] period);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".state"},  {24'd0, st},     {24'd0, e.st});
    chk({tag, ".sout"},   {31'd0, sout},   {31'd0, e.sout});
    chk({tag, ".busy"},   {31'd0, busy},   {31'd0, e.busy});
    chk({tag, ".done"},   {31'd0, done},   {31'd0, e.done});
    chk({tag, ".wrap"},   {31'd0, wrap},   {31'd0, e.wrap});
    chk({tag, ".lockup"}, {31'd0, lockup}, {31'd0, e.lockup});
    chk({tag, ".period"}, {24'd0, period}, {24'd0, e.period});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[24];
  logic [3:0] seqb[15];

  initial begin
    // rs, en, load, start, seed, nsteps, state, busy, done, lockup
    tbl[0]  = '{0, 1, 0, 0, 8'h00, 16'd0,  8'h03, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 8'h00, 16'd0,  8'h07, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 8'h00, 16'd0,  8'h0F, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 8'h00, 16'd0,  8'h1E, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 8'h00, 16'd0,  8'h3D, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 8'h00, 16'd0,  8'h00, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 8'h00, 16'd0,  8'h01, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 0, 8'h01, 16'd0,  8'h01, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 8'h00, 16'd3,  8'h01, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 8'h00, 16'd0,  8'h03, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 8'h00, 16'd5,  8'h07, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 8'h00, 16'd0,  8'h0F, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 8'h00, 16'd0,  8'h0F, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 8'h00, 16'd0,  8'h0F, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 8'h00, 16'd0,  8'h0F, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 8'h00, 16'd10, 8'h0F, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 8'h00, 16'd0,  8'h1E, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 8'h00, 16'd0,  8'h3D, 1, 0, 0};
    tbl[18] = '{0, 0, 1, 0, 8'hA5, 16'd0,  8'hA5, 0, 0, 0};
    tbl[19] = '{0, 0, 0, 0, 8'h00, 16'd0,  8'hA5, 0, 0, 0};
    tbl[20] = '{0, 0, 0, 1, 8'h00, 16'd10, 8'hA5, 1, 0, 0};
    tbl[21] = '{0, 0, 0, 0, 8'h00, 16'd0,  8'h4A, 1, 0, 0};
    tbl[22] = '{1, 0, 0, 0, 8'h00, 16'd0,  8'h01, 0, 0, 0};
    tbl[23] = '{0, 0, 0, 0, 8'h00, 16'd0,  8'h01, 0, 0, 0};
    seqb = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
             4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

    a_rs = 1'b1; a_en = 1'b0; a_load = 1'b0; a_scr = 1'b0; a_din = 1'b0;
    a_start = 1'b0; a_seed = 8'h00; a_nsteps = 16'd0;
    rs_bc = 1'b1; b_en = 1'b0; b_seed = 4'h0;
    c_en = 1'b0; c_load = 1'b0; c_seed = 8'h00;

    // Reset state of all three instances
    push(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    push(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    push(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    pop_cmp("rst_a", a_state, a_sout, a_busy, a_done, a_wrap, a_lockup, a_period);
    pop_cmp("rst_b", {4'h0, b_state}, b_sout, b_busy, b_done, b_wrap, b_lockup,
            {4'h0, b_period});
    pop_cmp("rst_c", c_state, c_sout, c_busy, c_done, c_wrap, c_lockup, c_period);
    a_rs = 1'b0;
    rs_bc = 1'b0;

    // Table-driven vectors on instance A
    for (int i = 0; i < 24; i++) begin
      a_rs = tbl[i].rs; a_en = tbl[i].en; a_load = tbl[i].load;
      a_start = tbl[i].start; a_seed = tbl[i].seed; a_nsteps = tbl[i].nsteps;
      push(tbl[i].st, tbl[i].st[7], tbl[i].busy, tbl[i].done, 1'b0, tbl[i].lockup, 8'h00);
      tick();
      pop_cmp($sformatf("vec%0d", i), a_state, a_sout, a_busy, a_done, a_wrap, a_lockup,
              a_period);
    end
    a_rs = 1'b0; a_en = 1'b0; a_load = 1'b0; a_start = 1'b0;

    // Scrambler: state 01 with din=1 folds out the tap parity
    a_scr = 1'b1; a_din = 1'b1; a_en = 1'b1;
    push(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    pop_cmp("scr", a_state, a_sout, a_busy, a_done, a_wrap, a_lockup, a_period);
    a_scr = 1'b0; a_din = 1'b0;
    push(8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    pop_cmp("noscr", a_state, a_sout, a_busy, a_done, a_wrap, a_lockup, a_period);
    a_en = 1'b0;

    // Idle hold
    push(8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    pop_cmp("hold", a_state, a_sout, a_busy, a_done, a_wrap, a_lockup, a_period);

    // Instance B: two full periods of the 4-bit sequence
    b_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      push({4'h0, seqb[k % 15]}, seqb[k % 15][3], 1'b0, 1'b0, (k % 15) == 0, 1'b0,
           (k >= 15) ? 8'd15 : 8'd0);
      tick();
      pop_cmp($sformatf("per%0d", k), {4'h0, b_state}, b_sout, b_busy, b_done, b_wrap,
              b_lockup, {4'h0, b_period});
    end
    b_en = 1'b0;

    // Instance C: XNOR lock-up is all-ones
    c_load = 1'b1; c_seed = 8'hFF;
    push(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    pop_cmp("xn_load", c_state, c_sout, c_busy, c_done, c_wrap, c_lockup, c_period);
    c_load = 1'b0; c_en = 1'b1;
    push(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    pop_cmp("xn_lock", c_state, c_sout, c_busy, c_done, c_wrap, c_lockup, c_period);
    push(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    pop_cmp("xn_step", c_state, c_sout, c_busy, c_done, c_wrap, c_lockup, c_period);
    c_en = 1'b0;

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised Fibonacci LFSR for pattern generation and data scrambling. Features:
- Configurable width, tap mask and XOR/XNOR feedback.
- Seed load, continuous-enable and counted-burst stepping.
- Automatic lock-up recovery and on-line period measurement.

Used by test-pattern and BIST logic to produce pseudo-random words and serial streams.

Parameters:
WIDTH, 8, register width (>=3).
TAPS, 8'hC9, feedback tap mask; bit i=1 includes state[i] in feedback (TAPS[WIDTH-1] must be 1).
SEED, 8'h01, reset/recovery value; must not equal the lock-up value.
XNOR, 0, 0 = XOR feedback (lock-up state all-zeros); 1 = XNOR feedback (lock-up state all-ones).
CNT_W, 16, width of the burst step counter.

Ports:
clk  in  1  clock, rising edge
rs  in  1  synchronous active-high reset
en  in  1  step once per cycle while high (ignored while busy)
load  in  1  load seed_in this cycle
seed_in  in  WIDTH  value for load
scr  in  1  scrambler mode: din is XORed into feedback
din  in  1  serial data for scrambler mode
start  in  1  begin burst of nsteps steps (sampled only when not busy)
nsteps  in  CNT_W  burst length
state  out  WIDTH  current register
sout  out  1  state[WIDTH-1]
busy  out  1  burst in progress
done  out  1  one-cycle pulse at end of burst
wrap  out  1  one-cycle pulse when sequence returns to reference value
lockup  out  1  one-cycle pulse when recovery performed
period  out  WIDTH  last measured period (steps between reference hits)

Behaviour:
- Everything is registered on the rising edge of clk. Reset is synchronous and active-high. Priority is rs > load > burst step > en step.
- Reset values:
  - state = SEED.
  - busy = 0, done = 0, wrap = 0, lockup = 0, period = 0.
  - Internal step count = 0; reference = SEED.
- Step:
  - fb = reduction XOR of (state & TAPS), inverted if XNOR=1, then XOR din if scr=1.
  - state <= {state[WIDTH-2:0], fb}.
- Lock-up: if a step is taken while state equals the lock-up value, the step loads SEED instead. lockup pulses for one cycle. The step count restarts at 0 and no wrap is flagged.
- load:
  - state <= seed_in, and reference <= seed_in.
  - Step count clears; period is unchanged.
  - Aborts any burst: busy <= 0, no done pulse.
  - Loading the lock-up value is accepted; it is recovered on the next step.
- Period measurement:
  - Each step increments the step count.
  - If the next state equals the reference: period <= count+1, wrap pulses, and the count clears.
  - Measurement is valid only with scr=0; with scr=1, wrap/period still update but are not meaningful.
- Burst FSM:
  - IDLE: start=1 with nsteps>0 moves to RUN, busy=1, remaining=nsteps. start=1 with nsteps=0 pulses done the next cycle and takes no step.
  - RUN: one step per cycle. When the last step is taken, the FSM returns to IDLE, busy drops and done pulses in that same cycle. A burst of N gives exactly N steps, and busy is high for N cycles.
  - start and en are ignored while busy.
  - rs mid-burst returns the FSM to IDLE with the reset values.
- sout is combinational from state (no extra latency).
- en=0 with no burst running holds state.

Test Plan:
- WIDTH=8, TAPS=C9, XNOR=0: reset, then en=1 for 5 cycles -> state 01,03,07,0F,1E,3D; sout=0 throughout.
- WIDTH=4, TAPS=9, SEED=1: en=1 continuously -> wrap pulses every 15 steps; period=15 after the first wrap; state sequence 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8,1.
- load seed_in=00 (XOR mode), then en=1 -> next state=SEED (01), lockup pulses once, no wrap.
- start with nsteps=3 while en=0 -> busy high for 3 cycles, state 01->03->07->0F, done pulses in the 3rd cycle; start with nsteps=0 -> done next cycle, state unchanged.
- Burst nsteps=10 with load asserted in the 4th busy cycle -> state=seed_in, busy=0, no done; rs mid-burst -> state=01, busy=0.
- XNOR=1, SEED=00, load FF, en=1 -> lockup pulse, state=00; scr=1 with din=1, state=01 (XOR mode) -> next state=02.
